// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 5x5 streaming convolution engine.
// Streams one image into the engine and writes valid-window results.
module conv_frame_ctrl #(
  parameter int DIM = 32,
  parameter int K   = 5,
  parameter int PP  = 8,
  parameter int AW  = 10,
  parameter int OAW = 10,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  input  logic [PP:0]    rd_data,
  output logic [PP:0]    pxl_out,
  output logic           conv_rst,
  input  logic [PP:0]    conv_in,
  output logic           wr_en,
  output logic [OAW-1:0] wr_addr,
  output logic [PP:0]    wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DW = $clog2(LAT + 2);

  logic [2:0]     r_state;
  logic [DW-1:0]  r_drn;
  logic [AW-1:0]  r_rd_addr;
  logic [RW-1:0]  r_row;
  logic [RW-1:0]  r_col;
  logic           r_rd_en_d;
  logic           r_tag_vld [LAT];
  logic [RW-1:0]  r_tag_row [LAT];
  logic [RW-1:0]  r_tag_col [LAT];
  logic           r_wr_en;
  logic [OAW-1:0] r_wr_addr;
  logic [PP:0]    r_wr_data;
  logic [OAW-1:0] r_res_cnt;

  logic w_last;
  logic w_tag_valid;

  assign w_last = (r_row == RW'(DIM - 1))
               && (r_col == RW'(DIM - 1));

  // Tag at the end of the pipe lines up with the engine result.
  assign w_tag_valid = r_tag_vld[LAT-1]
                    && (r_tag_row[LAT-1] >= RW'(K - 1))
                    && (r_tag_col[LAT-1] >= RW'(K - 1));

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign rd_en    = (r_state == S_READ);
  assign rd_addr  = r_rd_addr;
  assign conv_rst = reset | (r_state == S_CLEAR);
  assign pxl_out  = r_rd_en_d ? rd_data : '0;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_drn   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_CLEAR;
        end
        S_CLEAR: r_state <= S_READ;
        S_READ: begin
          if (w_last) begin
            r_state <= S_DRAIN;
            r_drn   <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drn == DW'(LAT)) r_state <= S_DONE;
          else                   r_drn   <= r_drn + 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || r_state == S_CLEAR) begin
      r_rd_addr <= '0;
      r_row     <= '0;
      r_col     <= '0;
    end else if (r_state == S_READ) begin
      r_rd_addr <= r_rd_addr + 1'b1;
      if (r_col == RW'(DIM - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en_d <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_row[i] <= '0;
        r_tag_col[i] <= '0;
      end
    end else begin
      r_rd_en_d    <= rd_en;
      r_tag_vld[0] <= rd_en;
      r_tag_row[0] <= r_row;
      r_tag_col[0] <= r_col;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
        r_tag_col[i] <= r_tag_col[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_res_cnt <= '0;
    end else begin
      r_wr_en <= w_tag_valid;
      if (r_state == S_CLEAR) begin
        r_res_cnt <= '0;
      end else if (w_tag_valid) begin
        r_wr_addr <= r_res_cnt;
        r_wr_data <= conv_in;
        r_res_cnt <= r_res_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl: cycle-exact frame model,
// engine modelled as pass-through, image pixel n = n % 128.
module tb_conv_frame_ctrl;

  localparam int DIM = 32;
  localparam int K   = 5;
  localparam int PP  = 8;
  localparam int AW  = 10;
  localparam int OAW = 10;
  localparam int LAT = 1;
  localparam int NW  = DIM - K + 1;
  localparam int NPX = DIM * DIM;
  localparam int DONE_C = NPX + 3 + LAT;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           busy, done, rd_en, conv_rst, wr_en;
  logic [AW-1:0]  rd_addr;
  logic [PP:0]    rd_data = '0;
  logic [PP:0]    pxl_out;
  logic [PP:0]    conv_in;
  logic [OAW-1:0] wr_addr;
  logic [PP:0]    wr_data;

  int cyc = 0;
  int t0 = 0;
  int wcnt = 0;
  int n_vec = 0;
  int n_err = 0;
  bit act = 0;
  bit rst_d = 0;

  conv_frame_ctrl #(
    .DIM(DIM), .K(K), .PP(PP), .AW(AW), .OAW(OAW), .LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pxl_out(pxl_out), .conv_rst(conv_rst), .conv_in(conv_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) rd_data <= {2'b00, rd_addr[6:0]};

  assign conv_in = pxl_out;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s cyc=%0d rel=%0d got=%0d exp=%0d",
                 tag, cyc, cyc - t0, got, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic r);
    int rel, n;
    bit e_wr;
    start = s;
    reset = r;
    @(negedge clk);
    rel = cyc - t0;
    n = rel - 3 - LAT;
    e_wr = act && n >= 0 && n < NPX
        && n / DIM >= K - 1 && n % DIM >= K - 1;
    chk("busy", 32'(busy),
        32'(act && rel >= 1 && rel <= DONE_C));
    chk("done", 32'(done), 32'(act && rel == DONE_C));
    chk("rd_en", 32'(rd_en),
        32'(act && rel >= 2 && rel <= NPX + 1));
    chk("conv_rst", 32'(conv_rst),
        32'(r || (act && rel == 1)));
    chk("pxl_out", 32'(pxl_out),
        (act && rel >= 3 && rel <= NPX + 2) ?
        32'((rel - 3) % 128) : 32'd0);
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    if (act && rel >= 2 && rel <= NPX + 1)
      chk("rd_addr", 32'(rd_addr), 32'(rel - 2));
    if (e_wr) begin
      chk("wr_addr", 32'(wr_addr),
          32'((n / DIM - K + 1) * NW + n % DIM - K + 1));
      chk("wr_data", 32'(wr_data), 32'(n % 128));
    end
    if (wr_en === 1'b1) wcnt++;
    if (act && rel == DONE_C)
      chk("wr_count", 32'(wcnt), 32'(NW * NW));
    if (rst_d) begin
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
    end
    @(posedge clk);
    rst_d = r;
    if (r) begin
      act = 0;
    end else if (s && (!act || rel > DONE_C)) begin
      t0 = cyc;
      act = 1;
      wcnt = 0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    repeat (3) cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0);

    // frame with stray starts while busy
    cycle(1'b1, 1'b0);
    for (int i = 1; i <= DONE_C + 6; i++)
      cycle(i == 10 || i == 500, 1'b0);

    // reset mid-frame, then restart
    cycle(1'b1, 1'b0);
    for (int i = 1; i < 300; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    for (int i = 301; i < 305; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 1; i <= DONE_C + 4; i++) cycle(1'b0, 1'b0);

    // start held high: back-to-back frames
    for (int i = 0; i < 2 * (DONE_C + 1) + 40; i++)
      cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
